// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared types, defaults and requantization for the MVM result collector
package mvm_pkg;

    localparam int MVM_K = 16;
    localparam int MVM_B = 8;

    typedef logic signed [2*MVM_B-1:0] acc_t;
    typedef logic signed [MVM_B-1:0]   res_t;

    typedef struct packed {
        logic last;
        res_t data;
    } fifo_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_CAPTURE
    } state_t;

    // Round half up, arithmetic shift, then clamp to the signed B-bit range.
    // One guard bit keeps x + rounding constant from wrapping.
    function automatic res_t requant(acc_t x, logic [4:0] shift);
        logic signed [2*MVM_B:0] w;
        logic signed [2*MVM_B:0] rnd;
        res_t r;
        w = {x[2*MVM_B-1], x};
        if (shift != 5'd0) begin
            rnd = '0;
            rnd[shift - 5'd1] = 1'b1;
            w = (w + rnd) >>> shift;
        end
        if (w[2*MVM_B] && !(&w[2*MVM_B:MVM_B-1])) begin
            r = {1'b1, {(MVM_B-1){1'b0}}};
        end else if (!w[2*MVM_B] && (|w[2*MVM_B:MVM_B-1])) begin
            r = {1'b0, {(MVM_B-1){1'b1}}};
        end else begin
            r = w[MVM_B-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mvm_result_fifo.sv
// rtl/mvm_result_fifo.sv - circular result FIFO with occupancy count, head shown while non-empty
module mvm_result_fifo
    import mvm_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_valid_i,
    input  fifo_entry_t push_entry_i,
    input  logic        pop_ready_i,
    output logic        out_valid_o,
    output fifo_entry_t out_entry_o,
    output logic [CW-1:0] count_o
);

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;

    assign pop = pop_ready_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_valid_i) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        case ({push_valid_i, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_valid_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Head forced to zero when empty so stale storage never leaks onto the stream.
    assign out_valid_o = (count_q != '0);
    assign out_entry_o = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o     = count_q;

endmodule

// File: rtl/mvm_result_collector.sv
// rtl/mvm_result_collector.sv - captures K MVM results per done pulse, requantizes, queues them
// Optional build macro RESULT_RELU_EN clamps negative requantized results to zero.
module mvm_result_collector
    import mvm_pkg::*;
#(
    parameter int K     = MVM_K,
    parameter int B     = MVM_B,
    parameter int SHIFT = 4,
    parameter int DEPTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           done_in,
    input  logic [2*B-1:0] data_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [B-1:0]   out_data,
    output logic           out_last,
    output logic           busy,
    output logic           overflow
);

    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic          busy_q;
    logic          overflow_q;
    logic [CW-1:0] fifo_count;
    logic          admit;
    logic          push_valid;
    res_t          res_sat;
    res_t          res_out;
    fifo_entry_t   push_entry;
    fifo_entry_t   head;

    // A whole vector is reserved up front, so the capture pushes never see a full FIFO.
    assign admit = ({1'b0, fifo_count} + (CW+1)'(K)) <= (CW+1)'(DEPTH);

    assign res_sat = requant(acc_t'(data_in), 5'(SHIFT));

`ifdef RESULT_RELU_EN
    assign res_out = res_sat[B-1] ? '0 : res_sat;
`else
    assign res_out = res_sat;
`endif

    assign push_valid      = (state_q == ST_CAPTURE);
    assign push_entry.last = (idx_q == IW'(K - 1));
    assign push_entry.data = res_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (done_in) begin
                        if (admit) begin
                            state_q <= ST_CAPTURE;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == IW'(K - 1)) begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    mvm_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_valid_i (push_valid),
        .push_entry_i (push_entry),
        .pop_ready_i  (out_ready),
        .out_valid_o  (out_valid),
        .out_entry_o  (head),
        .count_o      (fifo_count)
    );

    assign out_data = head.data;
    assign out_last = head.last;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mvm_result_collector.sv
// tb/tb_mvm_result_collector.sv - randomized self-checking bench with a queue-based reference model
module tb_mvm_result_collector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        done_in = 1'b0;
    logic [15:0] data_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        overflow;

    always #5 clk = ~clk;

    mvm_result_collector dut (
        .clk       (clk),
        .reset     (reset),
        .done_in   (done_in),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
    } ent_t;

    int passed = 0;
    int total  = 0;

    ent_t        exp_q[$];
    logic [15:0] drv_q[$];
    logic [15:0] preset_q[$];
    int          cap_rem = 0;
    bit          ovf_m = 0;

    logic       o_v, o_l, o_b, o_o;
    logic [7:0] o_d;
    logic       m_v, m_l, m_b;
    logic [7:0] m_d;
    bit         popped, admitted;

    function automatic logic [7:0] ref_requant(logic [15:0] raw);
        int x, v;
        logic [31:0] vb;
        x = int'($signed(raw));
        v = int'($floor(real'(x) / 16.0 + 0.5));
        if (v > 127) v = 127;
        if (v < -128) v = -128;
`ifdef RESULT_RELU_EN
        if (v < 0) v = 0;
`endif
        vb = v;
        return vb[7:0];
    endfunction

    // Samples the current cycle, advances the model by one clock and drives the next inputs.
    task automatic step(input bit done, input bit rdy);
        logic [15:0] d;
        ent_t e;
        int cnt;
        @(negedge clk);
        o_v = out_valid; o_d = out_data; o_l = out_last; o_b = busy; o_o = overflow;
        cnt = exp_q.size();
        m_v = (cnt != 0);
        m_b = (cap_rem > 0);
        m_d = m_v ? exp_q[0].data : 8'd0;
        m_l = m_v ? exp_q[0].last : 1'b0;
        popped = o_v && rdy;
        admitted = 0;
        d = 16'($urandom);
        if (cap_rem > 0) begin
            d = drv_q.pop_front();
            e.data = ref_requant(d);
            e.last = (cap_rem == 1);
            cap_rem--;
        end else if (done) begin
            if (cnt + 16 <= 32) begin
                admitted = 1;
                cap_rem = 16;
                for (int i = 0; i < 16; i++) begin
                    if (preset_q.size() > 0) drv_q.push_back(preset_q.pop_front());
                    else drv_q.push_back(16'($urandom));
                end
            end else begin
                ovf_m = 1;
            end
        end
        if (popped && cnt > 0) void'(exp_q.pop_front());
        if (m_b) exp_q.push_back(e);
        done_in = done;
        out_ready = rdy;
        data_in = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; done_in = 1'b0; out_ready = 1'b0;
        exp_q.delete(); drv_q.delete(); preset_q.delete();
        cap_rem = 0; ovf_m = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 8'd0) $display("FAIL reset_data: got %0d want 0", out_data); else passed++;
        total++; if (out_last !== 1'b0) $display("FAIL reset_last: got %b want 0", out_last); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passed++;
    endtask

    task automatic test_single_vector();
        int n = 0, busy_cnt = 0, first_v = -1;
        do_reset();
        for (int i = 0; i < 16; i++) preset_q.push_back(16'(16 * i));
        step(1, 1);
        for (int c = 1; c < 40; c++) begin
            step(0, 1);
            if (o_b === 1'b1) busy_cnt++;
            if (o_v === 1'b1 && first_v < 0) first_v = c;
            if (popped) begin
                total++; if (o_d !== 8'(n)) $display("FAIL single_data[%0d]: got %0d want %0d", n, o_d, n); else passed++;
                total++; if (o_l !== (n == 15)) $display("FAIL single_last[%0d]: got %b want %b", n, o_l, n == 15); else passed++;
                n++;
            end
        end
        total++; if (n != 16) $display("FAIL single_count: got %0d want 16", n); else passed++;
        total++; if (busy_cnt != 16) $display("FAIL single_busy_cycles: got %0d want 16", busy_cnt); else passed++;
        total++; if (first_v != 2) $display("FAIL single_latency: got %0d want 2", first_v); else passed++;
    endtask

    task automatic test_rounding();
        int xin[8]  = '{24, -24, 32767, -32768, 8, -8, 7, -9};
`ifdef RESULT_RELU_EN
        int xout[8] = '{2, 0, 127, 0, 1, 0, 0, 0};
`else
        int xout[8] = '{2, -1, 127, -128, 1, 0, 0, -1};
`endif
        int n = 0;
        int w;
        do_reset();
        for (int i = 0; i < 16; i++) preset_q.push_back((i < 8) ? 16'(xin[i]) : 16'd0);
        step(1, 1);
        for (int c = 0; c < 40; c++) begin
            step(0, 1);
            if (popped && n < 8) begin
                w = xout[n];
                total++; if (o_d !== w[7:0]) $display("FAIL round[%0d] x=%0d: got %0d want %0d", n, xin[n], $signed(o_d), w); else passed++;
                n++;
            end
        end
        total++; if (n != 8) $display("FAIL round_count: got %0d want 8", n); else passed++;
    endtask

    task automatic test_backpressure();
        int n = 0, derr = 0;
        do_reset();
        step(1, 0);
        for (int c = 0; c < 16; c++) step(0, 0);
        step(1, 0);
        for (int c = 0; c < 16; c++) step(0, 0);
        step(0, 0);
        total++; if (o_o !== 1'b0) $display("FAIL bp_overflow_before: got %b want 0", o_o); else passed++;
        step(1, 0);
        step(0, 0);
        total++; if (o_o !== 1'b1) $display("FAIL bp_overflow_set: got %b want 1", o_o); else passed++;
        total++; if (o_b !== 1'b0) $display("FAIL bp_no_capture: got busy %b want 0", o_b); else passed++;
        for (int c = 0; c < 60; c++) begin
            step(0, 1);
            if (popped) begin
                if (o_d !== m_d) derr++;
                total++; if (o_l !== (n == 15 || n == 31)) $display("FAIL bp_last[%0d]: got %b want %b", n, o_l, n == 15 || n == 31); else passed++;
                n++;
            end
        end
        total++; if (n != 32) $display("FAIL bp_drain_count: got %0d want 32", n); else passed++;
        total++; if (derr != 0) $display("FAIL bp_data: got %0d bad entries want 0", derr); else passed++;
        total++; if (o_o !== 1'b1) $display("FAIL bp_overflow_sticky: got %b want 1", o_o); else passed++;
    endtask

    task automatic test_ignored_done();
        int n = 0, busy_cnt = 0, derr = 0;
        do_reset();
        step(1, 1);
        for (int c = 1; c < 40; c++) begin
            step(c == 6, 1);
            if (o_b === 1'b1) busy_cnt++;
            if (popped) begin
                if (o_d !== m_d || o_l !== m_l) derr++;
                n++;
            end
        end
        total++; if (n != 16) $display("FAIL ign_count: got %0d want 16", n); else passed++;
        total++; if (busy_cnt != 16) $display("FAIL ign_busy_cycles: got %0d want 16", busy_cnt); else passed++;
        total++; if (derr != 0) $display("FAIL ign_data: got %0d bad entries want 0", derr); else passed++;
        total++; if (o_o !== 1'b0) $display("FAIL ign_overflow: got %b want 0", o_o); else passed++;
    endtask

    task automatic test_reset_mid_capture();
        int n = 0, lasts = 0, derr = 0, vcnt = 0;
        do_reset();
        step(1, 0);
        for (int c = 1; c <= 8; c++) step(0, c >= 2 && c <= 5);
        total++; if (o_v !== 1'b1) $display("FAIL mid_queued: got valid %b want 1", o_v); else passed++;
        do_reset();
        total++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", out_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
        for (int c = 0; c < 3; c++) begin
            step(0, 1);
            if (o_v === 1'b1) vcnt++;
        end
        total++; if (vcnt != 0) $display("FAIL mid_count_zero: got %0d valid cycles want 0", vcnt); else passed++;
        step(1, 1);
        for (int c = 0; c < 40; c++) begin
            step(0, 1);
            if (popped) begin
                if (o_d !== m_d) derr++;
                if (o_l === 1'b1) lasts++;
                n++;
            end
        end
        total++; if (n != 16) $display("FAIL mid_next_count: got %0d want 16", n); else passed++;
        total++; if (derr != 0) $display("FAIL mid_next_data: got %0d bad entries want 0", derr); else passed++;
        total++; if (lasts != 1) $display("FAIL mid_next_last: got %0d want 1", lasts); else passed++;
    endtask

    task automatic test_random_stream();
        int vec = 0, pops = 0, cyc = 0;
        int err_v = 0, err_b = 0, err_d = 0, err_s = 0;
        bit stall = 0, rdy;
        logic [7:0] held_d;
        logic held_l;
        do_reset();
        while ((vec < 100 || cap_rem > 0 || exp_q.size() > 0) && cyc < 20000) begin
            rdy = ($urandom_range(0, 9) < 7);
            step(vec < 100 && $urandom_range(0, 3) == 0, rdy);
            cyc++;
            if (admitted) vec++;
            if (o_v !== m_v) err_v++;
            if (o_b !== m_b) err_b++;
            if (stall && (o_d !== held_d || o_l !== held_l)) err_s++;
            if (popped) begin
                if (o_d !== m_d || o_l !== m_l) err_d++;
                pops++;
            end
            stall = o_v && !rdy;
            held_d = o_d;
            held_l = o_l;
        end
        step(0, 0);
        total++; if (vec != 100) $display("FAIL rand_vectors: got %0d want 100", vec); else passed++;
        total++; if (pops != 1600) $display("FAIL rand_pops: got %0d want 1600", pops); else passed++;
        total++; if (err_v != 0) $display("FAIL rand_valid: got %0d mismatching cycles want 0", err_v); else passed++;
        total++; if (err_b != 0) $display("FAIL rand_busy: got %0d mismatching cycles want 0", err_b); else passed++;
        total++; if (err_d != 0) $display("FAIL rand_data: got %0d bad entries want 0", err_d); else passed++;
        total++; if (err_s != 0) $display("FAIL rand_stable: got %0d unstable stalls want 0", err_s); else passed++;
        total++; if (o_o !== ovf_m) $display("FAIL rand_overflow: got %b want %b", o_o, ovf_m); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_vector();
        test_rounding();
        test_backpressure();
        test_ignored_done();
        test_reset_mid_capture();
        test_random_stream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
